rx_paridad: RTL and testbench
=============================

RX_PARIDAD -- requirements
Module: rx_paridad

Interface
REQ-001 Parameter: DATA_W, default 7, width of the data field in bits.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 tick  input  1  bit strobe; rx is sampled only on clk edges where tick=1.
REQ-005 rx  input  1  serial line; idle high; frame = start(0), DATA_W data bits LSB first, parity bit, stop(1).
REQ-006 parimpar  input  1  parity mode: 0 = even, 1 = odd; held stable for the whole frame.
REQ-007 data  output  DATA_W  last received data word, registered.
REQ-008 paridad  output  1  last received parity bit, registered.
REQ-009 data_valid  output  1  one-cycle pulse marking completion of a frame.
REQ-010 error_paridad  output  1  parity mismatch flag for the frame; qualified by data_valid.
REQ-011 error_trama  output  1  stop-bit error flag for the frame (stop sampled 0); qualified by data_valid.
REQ-012 ocupado  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, DATOS, PARIDAD, STOP.
REQ-014 IDLE: on a tick with rx=0, go to DATOS and clear the bit counter. On a tick with rx=1, or with no tick, stay in IDLE.
REQ-015 DATOS: on each tick, store rx into data bit position [count] (LSB first) and increment the counter. After the DATA_W-th tick, go to PARIDAD.
REQ-016 PARIDAD: on a tick, capture rx as the received parity bit and go to STOP.
REQ-017 STOP: on a tick, evaluate the frame and return to IDLE on the same edge.
REQ-018 Cycles with tick=0 SHALL leave the state, counter and shift register unchanged in every state.
REQ-019 The bit counter width SHALL be ceil(log2(DATA_W+1)). The counter SHALL never wrap inside a frame.
REQ-020 Expected parity SHALL be (^data_rx) XOR parimpar. Consequences:
- Even mode: ones in data plus parity bit is even.
- Odd mode: that total is odd.
REQ-021 error_paridad SHALL be 1 when the received parity bit differs from the expected parity.
REQ-022 error_trama SHALL be 1 when the stop-bit sample is 0.
REQ-023 At the STOP-tick edge the block SHALL register, on that one edge:
- data and paridad from the frame;
- error_paridad and error_trama from REQ-021 and REQ-022;
- data_valid=1.
data_valid SHALL drop to 0 on the next edge. Latency: valid is visible in the cycle after the stop-bit sample.
REQ-024 data, paridad, error_paridad and error_trama SHALL hold their values until the next frame completes. Partial frames SHALL never alter these outputs.
REQ-025 A frame with a stop error SHALL still deliver data and the parity check, with error_trama=1. The FSM SHALL return to IDLE and need a fresh 0 sample to start again.
REQ-026 A tick coinciding with the STOP-exit edge SHALL be consumed by STOP only. A start bit SHALL be detectable from the next tick onward, so back-to-back frames are supported with one stop bit.
REQ-027 ocupado SHALL be a registered decode of state != IDLE.

Reset
REQ-028 While reset_n=0 at a rising clk edge, the block SHALL:
- set state=IDLE and counter=0;
- set data=0, paridad=0, data_valid=0, error_paridad=0, error_trama=0, ocupado=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse. After release, reception SHALL resume only from a new start bit.
REQ-030 Reset SHALL take priority over tick on the same edge.

Verification
REQ-031 Even mode, valid frame: parimpar=0, frame 0 | 1,0,1,0,0,0,1 | 1 | 1 -> data=1000101, paridad=1, data_valid pulse once, error_paridad=0, error_trama=0.
REQ-032 Odd mode, same bits as REQ-031 (parity 1): parimpar=1 -> data=1000101, error_paridad=1.
REQ-033 Even mode, data 1100110 sent 0,1,1,0,0,1,1 with parity 0 then stop 0 -> data=1100110, error_paridad=0, error_trama=1. The FSM returns to IDLE.
REQ-034 Odd mode, data 1111111, parity 0, two frames back-to-back, ticks every 3 clk cycles -> two data_valid pulses, both error-free. ocupado stays high except during idle ticks between frames.
REQ-035 Reset after the 4th data tick of a frame -> no data_valid pulse, all outputs 0. A following complete frame of data 0000001 (even, parity 1) is received correctly.
REQ-036 Idle line: rx=1 with 20 ticks -> ocupado=0, no data_valid, and outputs keep their prior values.

Source files
------------

// File: rtl/rx_paridad.sv
// Serial receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// rx is sampled only on tick; frame results are registered and flagged by a one-cycle data_valid.
module rx_paridad #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              rx,
    input  logic              parimpar,
    output logic [DATA_W-1:0] data,
    output logic              paridad,
    output logic              data_valid,
    output logic              error_paridad,
    output logic              error_trama,
    output logic              ocupado
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, STOP} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count, count_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic              par_rx, par_rx_next;
    logic              frame_done;

    function automatic logic expected_parity(input logic [DATA_W-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    always_comb begin
        state_next  = state;
        count_next  = count;
        shift_next  = shift;
        par_rx_next = par_rx;
        frame_done  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state_next = DATOS;
                        count_next = '0;
                    end
                end
                DATOS: begin
                    // Shifting in from the MSB end leaves the first bit at position 0 after DATA_W ticks.
                    shift_next = {rx, shift[DATA_W-1:1]};
                    count_next = count + CW'(1);
                    if (count == CW'(DATA_W - 1)) begin
                        state_next = PARIDAD;
                    end
                end
                PARIDAD: begin
                    par_rx_next = rx;
                    state_next  = STOP;
                end
                STOP: begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            shift   <= '0;
            par_rx  <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            shift   <= shift_next;
            par_rx  <= par_rx_next;
            ocupado <= (state_next != IDLE);
        end
    end

    // Frame results only change on the stop-bit tick; partial frames never touch them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data          <= '0;
            paridad       <= 1'b0;
            data_valid    <= 1'b0;
            error_paridad <= 1'b0;
            error_trama   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (frame_done) begin
                data          <= shift;
                paridad       <= par_rx;
                error_paridad <= (par_rx != expected_parity(shift, parimpar));
                error_trama   <= ~rx;
                data_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_paridad.sv
// Directed bench for rx_paridad: frames are pushed to a scoreboard as they are sent
// and compared when data_valid appears.
module tb_rx_paridad;

    localparam int DATA_W = 7;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              paridad;
        logic              error_paridad;
        logic              error_trama;
    } result_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tick = 1'b0;
    logic              rx = 1'b1;
    logic              parimpar = 1'b0;
    logic [DATA_W-1:0] data;
    logic              paridad;
    logic              data_valid;
    logic              error_paridad;
    logic              error_trama;
    logic              ocupado;

    int      checks = 0;
    int      errors = 0;
    int      gap = 2;
    int      n_pushed = 0;
    int      n_valid = 0;
    result_t sb[$];
    result_t last = '0;

    rx_paridad #(.DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick(tick),
        .rx(rx),
        .parimpar(parimpar),
        .data(data),
        .paridad(paridad),
        .data_valid(data_valid),
        .error_paridad(error_paridad),
        .error_trama(error_trama),
        .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("unexpected_data_valid", 32'(data_valid), 32'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                check("data", 32'(data), 32'(e.data));
                check("paridad", 32'(paridad), 32'(e.paridad));
                check("error_paridad", 32'(error_paridad), 32'(e.error_paridad));
                check("error_trama", 32'(error_trama), 32'(e.error_trama));
            end
        end
    end

    task automatic send_bit(input logic b);
        rx   = b;
        tick = 1'b1;
        @(negedge clk);
        if (gap > 1) begin
            tick = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par,
                              input logic stop, input logic pm);
        result_t e;
        parimpar = pm;
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit(par);
        e.data          = d;
        e.paridad       = par;
        e.error_paridad = (par != ((^d) ^ pm));
        e.error_trama   = ~stop;
        sb.push_back(e);
        last = e;
        n_pushed++;
        send_bit(stop);
        tick = 1'b0;
        rx   = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'd0);
        check("reset_paridad", 32'(paridad), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        check("reset_error_paridad", 32'(error_paridad), 32'd0);
        check("reset_error_trama", 32'(error_trama), 32'd0);
        check("reset_ocupado", 32'(ocupado), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Even mode, valid frame
        gap = 2;
        send_frame(7'b1000101, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("ocupado_after_frame1", 32'(ocupado), 32'd0);

        // Odd mode, same bits -> parity error
        send_frame(7'b1000101, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);

        // Stop-bit error still delivers data
        send_frame(7'b1100110, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
        @(negedge clk);
        check("ocupado_after_stop_err", 32'(ocupado), 32'd0);

        // Back-to-back odd frames, tick every 3 clocks
        gap = 3;
        parimpar = 1'b1;
        send_frame(7'b1111111, 1'b0, 1'b1, 1'b1);
        send_frame(7'b1111111, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("ocupado_after_b2b", 32'(ocupado), 32'd0);

        // Ticks on every clock
        gap = 1;
        send_frame(7'b0110011, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);

        // Reset after the 4th data tick aborts the frame
        gap = 2;
        parimpar = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("ocupado_mid_frame", 32'(ocupado), 32'd1);
        reset_n = 1'b0;
        tick = 1'b1;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_data", 32'(data), 32'd0);
        check("abort_paridad", 32'(paridad), 32'd0);
        check("abort_error_paridad", 32'(error_paridad), 32'd0);
        check("abort_error_trama", 32'(error_trama), 32'd0);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        tick = 1'b0;
        rx = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ocupado_after_release", 32'(ocupado), 32'd0);
        send_frame(7'b0000001, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Idle line: outputs hold, nothing starts
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
            check("idle_ocupado", 32'(ocupado), 32'd0);
        end
        check("hold_data", 32'(data), 32'(last.data));
        check("hold_paridad", 32'(paridad), 32'(last.paridad));
        check("hold_error_paridad", 32'(error_paridad), 32'(last.error_paridad));
        check("hold_error_trama", 32'(error_trama), 32'(last.error_trama));

        repeat (4) @(negedge clk);
        check("valid_pulse_count", 32'(n_valid), 32'(n_pushed));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
